nn_mac_engine: RTL

- Downstream consumer of the neural-network input FIFO.
- Pops packed (activation, weight) words from the FIFO and multiply-accumulates them in Q8.8 fixed point on top of a bias.
- Applies optional ReLU and saturation to the sum, then presents one 16-bit neuron result on a valid/ready output.
- One invocation computes one neuron dot product of programmable length.

---
 rtl/nn_mac_engine.sv | 118 +++++++++++
 1 files changed

// File: rtl/nn_mac_engine.sv
// Neural-network MAC engine: pops (activation, weight) Q8.8 pairs from the input FIFO,
// accumulates their products on top of a bias and emits one saturated, optionally ReLU'd result.
module nn_mac_engine #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8,
    parameter int ACC_W  = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [15:0]       bias,
    input  logic              relu_en,
    output logic              busy,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_ce,
    output logic              fifo_we,
    output logic [15:0]       result_data,
    output logic              result_valid,
    input  logic              result_ready
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

    localparam logic signed [ACC_W-9:0] SAT_MAX = (ACC_W-8)'(32'sd32767);
    localparam logic signed [ACC_W-9:0] SAT_MIN = (ACC_W-8)'(-32'sd32768);

    state_t                   state;
    logic signed [ACC_W-1:0]  acc;
    logic [LEN_W-1:0]         remaining;
    logic signed [15:0]       a_q;
    logic signed [15:0]       w_q;
    logic                     op_valid;
    logic                     relu_q;

    logic signed [31:0]       product;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-9:0]  shifted;
    logic [15:0]              f_result;
    logic                     pop;

    // rst gates the pop strobe so an abandoned job never steals a FIFO entry
    assign pop      = (state == RUN) && (remaining != '0) && !fifo_empty && !rst;
    assign fifo_ce  = pop;
    assign fifo_we  = 1'b0;
    assign busy     = (state != IDLE);

    assign product  = 32'(a_q) * 32'(w_q);
    assign acc_sum  = op_valid ? acc + {{(ACC_W-32){product[31]}}, product} : acc;
    assign bias_ext = {{(ACC_W-24){bias[15]}}, bias, 8'h00};
    assign shifted  = acc_sum[ACC_W-1:8];

    always_comb begin
        f_result = shifted[15:0];
        if (shifted > SAT_MAX)
            f_result = 16'h7FFF;
        else if (shifted < SAT_MIN)
            f_result = 16'h8000;
        if (relu_q && shifted[ACC_W-9])
            f_result = 16'h0000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            acc          <= '0;
            remaining    <= '0;
            a_q          <= '0;
            w_q          <= '0;
            op_valid     <= 1'b0;
            relu_q       <= 1'b0;
            result_data  <= '0;
            result_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    op_valid <= 1'b0;
                    if (start) begin
                        acc       <= bias_ext;
                        remaining <= len;
                        relu_q    <= relu_en;
                        state     <= (len != '0) ? RUN : DRAIN;
                    end
                end
                RUN: begin
                    acc <= acc_sum;
                    if (pop) begin
                        a_q       <= fifo_data[DATA_W-1:DATA_W-16];
                        w_q       <= fifo_data[15:0];
                        op_valid  <= 1'b1;
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1))
                            state <= DRAIN;
                    end else begin
                        op_valid <= 1'b0;
                    end
                end
                DRAIN: begin
                    acc          <= acc_sum;
                    op_valid     <= 1'b0;
                    result_data  <= f_result;
                    result_valid <= 1'b1;
                    state        <= OUT;
                end
                OUT: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
